// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous byte-writable RAM between the fetch (I) and data (D) ports.
// Defining MEMARB_PERF_EN adds grant and conflict performance counters.
module mem_arbiter #(
  parameter int ADDR_W = 22,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_valid,
  input  logic [31:0]       i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_valid,
  input  logic [31:0]       d_addr,
  input  logic [3:0]        d_wstrb,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef MEMARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_grant_i,
  output logic [PERF_W-1:0] perf_grant_d,
  output logic [PERF_W-1:0] perf_conflict
`endif
);

  // tag      | meaning
  // TAG_NONE | no read in flight
  // TAG_I    | fetch read in flight, response next cycle
  // TAG_D    | data read in flight, response next cycle
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_I    = 2'd1,
    TAG_D    = 2'd2
  } tag_e;

  tag_e        tag_q, tag_d;
  logic        last_d_q, last_d_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        grant_i, grant_d;

  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    tag_d     = TAG_NONE;
    last_d_d  = last_d_q;
    ram_wen   = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;

    if (resetn) begin
      // last_d_q=1 means D won last time, so I wins the next conflict
      grant_i  = i_valid & (~d_valid | last_d_q);
      grant_d  = d_valid & (~i_valid | ~last_d_q);
      i_rvalid = (tag_q == TAG_I);
      d_rvalid = (tag_q == TAG_D);
    end

    if (grant_i) begin
      ram_addr = i_addr[ADDR_W+1:2];
      tag_d    = TAG_I;
      last_d_d = 1'b0;
    end else if (grant_d) begin
      ram_addr  = d_addr[ADDR_W+1:2];
      ram_wen   = d_wstrb;
      ram_wdata = d_wdata;
      tag_d     = (d_wstrb == 4'b0000) ? TAG_D : TAG_NONE;
      last_d_d  = 1'b1;
    end

    i_rdata_d = i_rvalid ? ram_rdata : i_rdata_q;
    d_rdata_d = d_rvalid ? ram_rdata : d_rdata_q;
  end

  assign i_ready = grant_i;
  assign d_ready = grant_d;
  assign i_rdata = i_rdata_d;
  assign d_rdata = d_rdata_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tag_q     <= TAG_NONE;
      last_d_q  <= 1'b1;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      tag_q     <= tag_d;
      last_d_q  <= last_d_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef MEMARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_grant_i  <= '0;
      perf_grant_d  <= '0;
      perf_conflict <= '0;
    end else begin
      if (grant_i)            perf_grant_i  <= perf_grant_i + 1'b1;
      if (grant_d)            perf_grant_d  <= perf_grant_d + 1'b1;
      if (i_valid && d_valid) perf_conflict <= perf_conflict + 1'b1;
    end
  end
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], i_addr[31:ADDR_W+2], d_addr[1:0], d_addr[31:ADDR_W+2]};

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port, synchronous, byte-lane-writable data RAM between the CPU instruction-fetch port (I, read-only) and the CPU data port (D, read/write).
- Sits between the cpu and ram blocks. Issues at most one RAM access per cycle.
- Picks a winner round-robin on conflict, tracks which port owns the in-flight read, and routes the read data back one cycle later.

Parameters:
- ADDR_W, 22, width of the RAM word address; the RAM sees byte address bits [ADDR_W+1:2].
- PERF_W, 32, width of the performance counters (only used with MEMARB_PERF_EN).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- i_valid  in  1  fetch request.
- i_addr  in  32  fetch byte address; bits [1:0] ignored.
- i_ready  out  1  fetch request accepted this cycle (combinational).
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  32  fetch data.
- d_valid  in  1  data request.
- d_addr  in  32  data byte address; bits [1:0] ignored.
- d_wstrb  in  4  byte-lane write strobes; 0 = read.
- d_wdata  in  32  lane-aligned write data.
- d_ready  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  data read valid.
- d_rdata  out  32  data read value.
- ram_wen  out  4  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, registered inside the RAM, valid one cycle after the address.

Behaviour:
- Reset: sampled on rising clk while resetn=0. Clears all of the following:
  - i_rvalid=0, d_rvalid=0.
  - i_rdata=0, d_rdata=0.
  - Round-robin pointer last_grant=D, so I wins the first conflict.
  - In-flight tag cleared.
- Outputs during reset:
  - i_ready, d_ready and ram_wen forced to 0.
  - ram_addr=0 and ram_wdata=0.
- Grant decision (combinational, each cycle, resetn=1):
  - Only I valid: grant I.
  - Only D valid: grant D.
  - Both valid: grant the port not equal to last_grant.
  - Neither valid: no grant.
  - last_grant updates at the clock edge, only in grant cycles.
- RAM drive in the grant cycle:
  - ram_addr = granted addr[ADDR_W+1:2].
  - Grant to D: ram_wen = d_wstrb and ram_wdata = d_wdata.
  - Grant to I: ram_wen = 0.
  - No grant: ram_wen=0, ram_addr=0, ram_wdata=0.
- Handshake:
  - x_ready is high only in that port's grant cycle, and never for both ports in the same cycle.
  - Requester holds x_valid and its payload stable until x_ready=1.
  - A new request may be presented the very next cycle.
- Reads (I grant, or D grant with d_wstrb=0):
  - Tag register records the owner.
  - Next cycle: owner's x_rvalid=1 for exactly one cycle, x_rdata=ram_rdata.
  - No response backpressure.
  - x_rdata holds its last value while x_rvalid=0.
- Writes (d_wstrb≠0):
  - Complete in the grant cycle.
  - No d_rvalid is produced.
- Throughput: back-to-back grants are allowed, one per cycle. A read response and a new grant may coincide in the same cycle.
- Ordering:
  - Write at cycle N then read of the same word at N+1: returns the written data at N+2.
  - Read and write of the same word in one cycle is impossible (single grant).
- Starvation bound: with both ports continuously valid, grants strictly alternate I, D, I, D…; each port is granted within 2 cycles.
- Address wrap: address bits above ADDR_W+1 are ignored, so the RAM aliases.
- Reset mid-operation: an in-flight read is dropped; x_rvalid=0 in the cycle after reset is sampled.

Optional Feature:
- Macro: MEMARB_PERF_EN.
- When defined, adds three PERF_W-bit outputs, cleared on reset, wrapping at 2^PERF_W:
  - perf_grant_i: +1 per I grant.
  - perf_grant_d: +1 per D grant.
  - perf_conflict: +1 per cycle with i_valid=1 and d_valid=1.
- When undefined: the ports and logic are absent; the remaining behaviour is identical.

Test Plan:
- Reset, then idle → i_ready=d_ready=0, ram_wen=0, i_rvalid=d_rvalid=0 every cycle.
- Preload mem[4]=32'hdeadbeef; I read at addr 0x10 → i_ready=1 in the same cycle, ram_addr=4; next cycle i_rvalid=1, i_rdata=32'hdeadbeef, d_rvalid=0.
- Store, with mem[0]=32'hffffffff:
  - D write addr 0x1, d_wstrb=4'b0010, d_wdata=32'h00000100 → ram_wen=4'b0010, no d_rvalid; afterwards mem[0]=32'hffff01ff.
  - D read addr 0 on the next cycle → d_rvalid with d_rdata=32'hffff01ff.
- Both ports valid for 6 cycles straight after reset → grant order I,D,I,D,I,D; each read response goes to the correct port 1 cycle later.
  - With MEMARB_PERF_EN: perf_conflict=6, perf_grant_i=3, perf_grant_d=3.
- D read granted, resetn=0 on the following cycle → d_rvalid stays 0 and the pointer returns to reset state; the next conflict grants I.
- ram_addr wrap: I read addr 32'h0100_0010 with ADDR_W=22 → ram_addr=4.
